// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32 pipeline: load-use stalls,
// taken-branch flushes, data-memory wait freezes, timeout fault and perf counters.
module hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_EX,
    input  logic [4:0]       RD_EX,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic             uses_rs1_ID,
    input  logic             uses_rs2_ID,
    input  logic             branch_taken_EX,
    input  logic             mem_busy,
    input  logic             perf_clear,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             pipe_freeze,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           fsm_r;
    logic [7:0]       wait_cnt_r;
    logic             flush_pend_r;
    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] flush_events_r;

    logic freeze_s;
    logic flush_req_s;
    logic load_use_s;
    logic stall_inc_s;
    logic flush_inc_s;

    // Hazard detection and event qualification
    always_comb begin
        freeze_s    = 1'b0;
        flush_req_s = 1'b0;
        load_use_s  = 1'b0;
        if (fsm_r == ST_FAULT) begin
            freeze_s = 1'b1;
        end else begin
            freeze_s = mem_busy;
        end
        flush_req_s = branch_taken_EX | flush_pend_r;
        load_use_s  = MemRead_EX & (RD_EX != 5'd0) &
                      ((uses_rs1_ID & (RS1_ID == RD_EX)) |
                       (uses_rs2_ID & (RS2_ID == RD_EX)));
        stall_inc_s = freeze_s | (load_use_s & ~flush_req_s);
        flush_inc_s = ~freeze_s & flush_req_s;
    end

    // Pipeline control outputs; priority is freeze, then flush, then load-use
    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        pipe_freeze = 1'b0;
        if (reset) begin
            PCWrite     = 1'b1;
            IF_ID_Write = 1'b1;
        end else if (freeze_s) begin
            pipe_freeze = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (flush_req_s) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (load_use_s) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else begin
            PCWrite     = 1'b1;
            IF_ID_Write = 1'b1;
        end
    end

    // Wait-state FSM, pending flush and saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r          <= ST_RUN;
            wait_cnt_r     <= 8'd0;
            flush_pend_r   <= 1'b0;
            stall_cycles_r <= {CNT_W{1'b0}};
            flush_events_r <= {CNT_W{1'b0}};
        end else begin
            case (fsm_r)
                ST_RUN: begin
                    if (mem_busy) begin
                        fsm_r      <= ST_WAIT;
                        wait_cnt_r <= 8'd1;
                    end else begin
                        fsm_r      <= ST_RUN;
                        wait_cnt_r <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (!mem_busy) begin
                        fsm_r      <= ST_RUN;
                        wait_cnt_r <= 8'd0;
                    end else if (wait_cnt_r == MAX_WAIT_C) begin
                        fsm_r <= ST_FAULT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                ST_FAULT: begin
                    fsm_r <= ST_FAULT;
                end
                default: begin
                    fsm_r      <= ST_RUN;
                    wait_cnt_r <= 8'd0;
                end
            endcase

            // A branch seen while frozen is remembered until the pipe moves again
            if (freeze_s) begin
                flush_pend_r <= flush_pend_r | branch_taken_EX;
            end else begin
                flush_pend_r <= 1'b0;
            end

            if (perf_clear) begin
                stall_cycles_r <= {CNT_W{1'b0}};
                flush_events_r <= {CNT_W{1'b0}};
            end else begin
                if (stall_inc_s && (stall_cycles_r != CNT_MAX_C)) begin
                    stall_cycles_r <= stall_cycles_r + CNT_ONE_C;
                end
                if (flush_inc_s && (flush_events_r != CNT_MAX_C)) begin
                    flush_events_r <= flush_events_r + CNT_ONE_C;
                end
            end
        end
    end

    assign mem_fault    = (fsm_r == ST_FAULT);
    assign stall_cycles = stall_cycles_r;
    assign flush_events = flush_events_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MAX_WAIT=4, CNT_W=4).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       MemRead_EX;
    logic [4:0] RD_EX;
    logic [4:0] RS1_ID;
    logic [4:0] RS2_ID;
    logic       uses_rs1_ID;
    logic       uses_rs2_ID;
    logic       branch_taken_EX;
    logic       mem_busy;
    logic       perf_clear;
    logic       PCWrite;
    logic       IF_ID_Write;
    logic       IF_ID_Flush;
    logic       ID_EX_Flush;
    logic       pipe_freeze;
    logic       mem_fault;
    logic [3:0] stall_cycles;
    logic [3:0] flush_events;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .MemRead_EX(MemRead_EX), .RD_EX(RD_EX), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
        .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
        .branch_taken_EX(branch_taken_EX), .mem_busy(mem_busy), .perf_clear(perf_clear),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Flush(ID_EX_Flush), .pipe_freeze(pipe_freeze), .mem_fault(mem_fault),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controls packed as {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_freeze}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        #2;
        chk(tag, 32'({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_freeze}),
            32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        MemRead_EX = 1'b0; RD_EX = 5'd0; RS1_ID = 5'd0; RS2_ID = 5'd0;
        uses_rs1_ID = 1'b0; uses_rs2_ID = 1'b0; branch_taken_EX = 1'b0;
        mem_busy = 1'b0; perf_clear = 1'b0;
    endtask

    task automatic load_use_rs2(input logic [4:0] rd);
        MemRead_EX = 1'b1; RD_EX = rd; RS2_ID = rd; uses_rs2_ID = 1'b1;
    endtask

    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_FLUSH = 5'b11110;
    localparam logic [4:0] C_FRZ   = 5'b00001;

    initial begin
        idle();
        reset = 1'b1;
        mem_busy = 1'b1;
        branch_taken_EX = 1'b1;
        chk_ctl("reset_ctl", C_RUN);
        tick();
        reset = 1'b0;
        idle();
        chk_ctl("post_reset_ctl", C_RUN);
        chk("post_reset_stall", 32'(stall_cycles), 32'd0);
        chk("post_reset_flush", 32'(flush_events), 32'd0);
        chk("post_reset_fault", 32'(mem_fault), 32'd0);

        // load-use on rs2
        load_use_rs2(5'd5);
        chk_ctl("lu_rs2_ctl", C_STALL);
        tick();
        idle();
        chk_ctl("lu_after_ctl", C_RUN);
        chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);

        // x0 destination never stalls
        load_use_rs2(5'd0);
        chk_ctl("lu_x0_ctl", C_RUN);
        tick();
        chk("lu_x0_cnt", 32'(stall_cycles), 32'd1);

        // rs1 match stalls, but only when rs1 is actually read
        idle();
        MemRead_EX = 1'b1; RD_EX = 5'd7; RS1_ID = 5'd7; uses_rs1_ID = 1'b0;
        chk_ctl("lu_rs1_unused_ctl", C_RUN);
        uses_rs1_ID = 1'b1;
        chk_ctl("lu_rs1_ctl", C_STALL);
        tick();
        idle();
        chk("lu_rs1_cnt", 32'(stall_cycles), 32'd2);

        // plain taken branch
        branch_taken_EX = 1'b1;
        chk_ctl("br_ctl", C_FLUSH);
        tick();
        idle();
        chk_ctl("br_after_ctl", C_RUN);
        chk("br_flush_cnt", 32'(flush_events), 32'd1);

        // branch and load-use together: flush wins, no stall counted
        branch_taken_EX = 1'b1;
        load_use_rs2(5'd5);
        chk_ctl("br_lu_ctl", C_FLUSH);
        tick();
        idle();
        chk("br_lu_flush_cnt", 32'(flush_events), 32'd2);
        chk("br_lu_stall_cnt", 32'(stall_cycles), 32'd2);

        perf_clear = 1'b1;
        tick();
        perf_clear = 1'b0;
        chk("clear_stall", 32'(stall_cycles), 32'd0);
        chk("clear_flush", 32'(flush_events), 32'd0);

        // freeze with held branch, flush released on first unfrozen cycle
        branch_taken_EX = 1'b1;
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_ctl($sformatf("frz_ctl%0d", i), C_FRZ);
            tick();
        end
        mem_busy = 1'b0;
        chk_ctl("frz_release_ctl", C_FLUSH);
        tick();
        idle();
        chk("frz_flush_cnt", 32'(flush_events), 32'd1);
        chk("frz_stall_cnt", 32'(stall_cycles), 32'd3);

        // branch dropped during freeze still flushes once via the pending flag
        branch_taken_EX = 1'b1;
        mem_busy = 1'b1;
        tick();
        idle();
        chk_ctl("pend_ctl", C_FLUSH);
        tick();
        chk_ctl("pend_cleared_ctl", C_RUN);
        chk("pend_flush_cnt", 32'(flush_events), 32'd2);
        chk("pend_stall_cnt", 32'(stall_cycles), 32'd4);

        // timeout: fault after the 5th consecutive busy cycle
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("to_no_fault_yet", 32'(mem_fault), 32'd0);
        tick();
        chk("to_fault", 32'(mem_fault), 32'd1);
        mem_busy = 1'b0;
        chk_ctl("to_fault_ctl", C_FRZ);
        tick();
        chk("to_fault_sticky", 32'(mem_fault), 32'd1);
        reset = 1'b1;
        chk_ctl("to_reset_ctl", C_RUN);
        tick();
        reset = 1'b0;
        chk("to_reset_fault", 32'(mem_fault), 32'd0);
        chk_ctl("to_reset_run_ctl", C_RUN);

        // reset during WAIT discards a pending flush
        branch_taken_EX = 1'b1;
        mem_busy = 1'b1;
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_ctl("wait_reset_no_flush", C_RUN);
        chk("wait_reset_cnt", 32'(stall_cycles), 32'd0);

        // saturation at 15 with a held load-use
        load_use_rs2(5'd9);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", 32'(stall_cycles), 32'd15);

        // clear coinciding with increments
        perf_clear = 1'b1;
        branch_taken_EX = 1'b1;
        tick();
        chk("clr_inc_flush", 32'(flush_events), 32'd0);
        perf_clear = 1'b0;
        idle();
        load_use_rs2(5'd9);
        tick();
        perf_clear = 1'b1;
        tick();
        idle();
        chk("clr_inc_stall", 32'(stall_cycles), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
